ext_unit: RTL and testbench

EXT_UNIT -- requirements
Module: ext_unit

---
 rtl/ext_pkg.sv | 9 +
 rtl/ext_core.sv | 30 +++
 rtl/ext_unit.sv | 74 +++++++
 tb/tb_ext_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate-extension unit.
package ext_pkg;
  typedef enum logic [1:0] {
    EOP_SEXT = 2'b00,
    EOP_ZEXT = 2'b01,
    EOP_LUI  = 2'b10,
    EOP_BOFS = 2'b11
  } eop_t;
endpackage

// File: rtl/ext_core.sv
// Pure combinational immediate extension (sign/zero/load-upper/branch offset).
// Zero latency, no flow control; result is a function of imm and eop only.
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       eop,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    result = '0;
    case (eop_t'(eop))
      EOP_SEXT: result = sext;
      EOP_ZEXT: result = {{(OUT_W-IMM_W){1'b0}}, imm};
      EOP_LUI:  result = {imm, {(OUT_W-IMM_W){1'b0}}};
      // Shifting the sign-extended value discards the top two bits, which is the intended truncation.
      EOP_BOFS: result = sext << 2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit.sv
// Immediate extension with valid gating and zero flag; EXT_OUTREG_EN registers outputs (1 cycle), else 0-cycle comb.
// No backpressure: one result per in_valid cycle; synchronous active-high reset drops in-flight results.
module ext_unit
  import ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       EOp,
  output logic [OUT_W-1:0] ext,
  output logic             out_valid,
  output logic             ext_zero
);

  logic [IMM_W-1:0] imm_g;
  logic [1:0]       eop_g;
  logic [OUT_W-1:0] core_res;

  // Gate inputs so X on an unqualified imm/EOp never reaches the datapath.
  assign imm_g = in_valid ? imm : '0;
  assign eop_g = in_valid ? EOp : 2'b00;

  ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm    (imm_g),
    .eop    (eop_g),
    .result (core_res)
  );

`ifdef EXT_OUTREG_EN
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] ext_d, ext_q;
  logic             ext_zero_d, ext_zero_q;

  always_comb begin
    out_valid_d = in_valid;
    ext_d       = in_valid ? core_res : '0;
    ext_zero_d  = in_valid && (core_res == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      ext_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      ext_zero_q  <= ext_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ext       = ext_q;
  assign ext_zero  = ext_zero_q;
`else
  logic vld;

  assign vld       = in_valid & ~reset;
  assign out_valid = vld;
  assign ext       = vld ? core_res : '0;
  assign ext_zero  = vld && (core_res == '0);

  // Clock is otherwise unused in this build; the check documents the reset gating.
  reset_blocks_output: assert property (@(posedge clk) reset |-> !out_valid);
`endif

endmodule

// File: tb/tb_ext_unit.sv
// Directed + random bench for ext_unit with an expected-result queue; works with or without EXT_OUTREG_EN.
module tb_ext_unit;

  typedef struct packed {
    logic        v;
    logic [31:0] e;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic [31:0] ext;
  logic        out_valid;
  logic        ext_zero;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ext_unit #(.IMM_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .imm       (imm),
    .EOp       (EOp),
    .ext       (ext),
    .out_valid (out_valid),
    .ext_zero  (ext_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] im, input logic [1:0] op);
    logic [31:0] s;
    s = {{16{im[15]}}, im};
    case (op)
      2'b00:   model = s;
      2'b01:   model = {16'h0000, im};
      2'b10:   model = {im, 16'h0000};
      default: model = {s[29:0], 2'b00};
    endcase
  endfunction

  task automatic compare(input string tag);
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (out_valid === x.v) else begin
      failures++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, x.v);
    end
    checks++;
    assert (ext === x.e) else begin
      failures++;
      $error("FAIL %s ext observed=%h expected=%h", tag, ext, x.e);
    end
    checks++;
    assert (ext_zero === x.z) else begin
      failures++;
      $error("FAIL %s ext_zero observed=%b expected=%b", tag, ext_zero, x.z);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] im, input logic [1:0] op,
                      input logic ev, input logic [31:0] ee, input logic ez, input string tag);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    imm      = im;
    EOp      = op;
    sb.push_back('{v: ev, e: ee, z: ez});
`ifndef EXT_OUTREG_EN
    #1;
    compare(tag);
`endif
    @(posedge clk);
    #1;
`ifdef EXT_OUTREG_EN
    compare(tag);
`endif
  endtask

  task automatic mstep(input logic r, input logic v, input logic [15:0] im, input logic [1:0] op,
                       input string tag);
    logic [31:0] e;
    e = model(im, op);
    if (r || !v) step(r, v, im, op, 1'b0, 32'h0, 1'b0, tag);
    else         step(r, v, im, op, 1'b1, e, (e == 32'h0), tag);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    imm      = '0;
    EOp      = '0;

    step(1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 32'h0, 1'b0, "reset_idle");
    step(1'b1, 1'b1, 16'h80F5, 2'b00, 1'b0, 32'h0, 1'b0, "reset_input_discarded");

    step(1'b0, 1'b1, 16'h80F5, 2'b11, 1'b1, 32'hFFFE03D4, 1'b0, "bofs_80f5");
    step(1'b0, 1'b1, 16'h80F5, 2'b00, 1'b1, 32'hFFFF80F5, 1'b0, "sext_80f5");
    step(1'b0, 1'b1, 16'h80F5, 2'b01, 1'b1, 32'h000080F5, 1'b0, "zext_80f5");
    step(1'b0, 1'b1, 16'h80F5, 2'b10, 1'b1, 32'h80F50000, 1'b0, "lui_80f5");
    step(1'b0, 1'b1, 16'h7FFF, 2'b00, 1'b1, 32'h00007FFF, 1'b0, "sext_7fff");
    step(1'b0, 1'b1, 16'h0000, 2'b10, 1'b1, 32'h00000000, 1'b1, "lui_zero");
    step(1'b0, 1'b1, 16'hC000, 2'b11, 1'b1, 32'hFFFF0000, 1'b0, "bofs_truncate");
    step(1'b0, 1'b0, 16'hxxxx, 2'bxx, 1'b0, 32'h0, 1'b0, "idle_x_inputs");

    // Stream with a one-cycle reset pulse in the middle.
    mstep(1'b0, 1'b1, 16'h1234, 2'b00, "stream_a");
    mstep(1'b0, 1'b1, 16'hFEDC, 2'b11, "stream_b");
    mstep(1'b1, 1'b1, 16'h5555, 2'b01, "stream_reset");
    mstep(1'b0, 1'b1, 16'hAAAA, 2'b10, "stream_resume_a");
    mstep(1'b0, 1'b1, 16'h8001, 2'b00, "stream_resume_b");

    for (int i = 0; i < 40; i++) begin
      mstep(($urandom_range(0, 15) == 0), $urandom_range(0, 3) != 0,
            16'($urandom), 2'($urandom_range(0, 3)), "random");
    end

    checks++;
    assert (sb.size() === 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
